// File: rtl/sys_bus_fabric.sv
// Single-master, N-slave window-decoded bus fabric with wait states, access watchdog and error responses.
// Optional error logging (err_addr / err_count) is enabled by defining BUS_ERR_LOG_EN.
module sys_bus_fabric #(
    parameter int                NUM_SLV  = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] SLV_BASE = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] SLV_SIZE = 32'h0000_1000,
    parameter int                TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         m_addr,
    input  logic [DATA_W-1:0]         m_wdata,
    input  logic                      m_rd_en,
    input  logic                      m_wr_en,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      m_ready,
    output logic                      m_err,
    output logic                      m_busy,
`ifdef BUS_ERR_LOG_EN
    output logic [ADDR_W-1:0]         err_addr,
    output logic [7:0]                err_count,
`endif
    output logic [NUM_SLV-1:0]        s_sel,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    output logic                      s_rd_en,
    output logic                      s_wr_en,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLV-1:0]        s_ready
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int EXT_W = ADDR_W + 4;
    localparam logic [NUM_SLV-1:0] SEL_ONE = NUM_SLV'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_r, state_nx;
    logic [IDX_W-1:0]    idx_r;
    logic                wr_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   m_rdata_r;
    logic                m_ready_r, m_err_r, m_busy_r;
    logic [NUM_SLV-1:0]  s_sel_r;
    logic [ADDR_W-1:0]   s_addr_r;
    logic [DATA_W-1:0]   s_wdata_r;
    logic                s_rd_en_r, s_wr_en_r;

    logic                req_s, both_s, hit_s, win_hit_s, sel_ready_s, timeout_s;
    logic [IDX_W-1:0]    idx_s;
    logic [ADDR_W-1:0]   off_s;
    logic [EXT_W-1:0]    addr_ext_s, win_lo_s;
    logic [DATA_W-1:0]   rdata_sel_s;

    // Window decode of the incoming address plus selected-slave status
    always_comb begin
        req_s       = m_rd_en | m_wr_en;
        both_s      = m_rd_en & m_wr_en;
        addr_ext_s  = EXT_W'(m_addr);
        hit_s       = 1'b0;
        win_hit_s   = 1'b0;
        win_lo_s    = {EXT_W{1'b0}};
        idx_s       = {IDX_W{1'b0}};
        off_s       = {ADDR_W{1'b0}};
        for (int i = 0; i < NUM_SLV; i++) begin
            win_lo_s  = EXT_W'(SLV_BASE) + EXT_W'(i) * EXT_W'(SLV_SIZE);
            win_hit_s = (addr_ext_s >= win_lo_s) && (addr_ext_s < win_lo_s + EXT_W'(SLV_SIZE));
            hit_s     = hit_s | win_hit_s;
            idx_s     = win_hit_s ? IDX_W'(i) : idx_s;
            off_s     = win_hit_s ? ADDR_W'(addr_ext_s - win_lo_s) : off_s;
        end
        sel_ready_s = s_ready[idx_r];
        rdata_sel_s = s_rdata[idx_r*DATA_W +: DATA_W];
        timeout_s   = (cnt_r == CNT_W'(TIMEOUT - 1));
    end

    // Next-state logic; a slave completion in the last watchdog cycle still wins
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    if (hit_s && !both_s) state_nx = ACCESS;
                    else                  state_nx = RESP;
                end else begin
                    state_nx = IDLE;
                end
            end
            ACCESS: begin
                if (sel_ready_s || timeout_s) state_nx = RESP;
                else                          state_nx = ACCESS;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register and all registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            idx_r     <= {IDX_W{1'b0}};
            wr_r      <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            m_rdata_r <= {DATA_W{1'b0}};
            m_ready_r <= 1'b0;
            m_err_r   <= 1'b0;
            m_busy_r  <= 1'b0;
            s_sel_r   <= {NUM_SLV{1'b0}};
            s_addr_r  <= {ADDR_W{1'b0}};
            s_wdata_r <= {DATA_W{1'b0}};
            s_rd_en_r <= 1'b0;
            s_wr_en_r <= 1'b0;
        end else begin
            state_r <= state_nx;
            case (state_r)
                IDLE: begin
                    cnt_r     <= {CNT_W{1'b0}};
                    m_ready_r <= 1'b0;
                    m_err_r   <= 1'b0;
                    if (req_s) begin
                        idx_r     <= idx_s;
                        wr_r      <= m_wr_en;
                        s_addr_r  <= off_s;
                        s_wdata_r <= m_wdata;
                        m_busy_r  <= 1'b1;
                        if (state_nx == ACCESS) begin
                            s_sel_r   <= SEL_ONE << idx_s;
                            s_rd_en_r <= m_rd_en;
                            s_wr_en_r <= m_wr_en;
                        end else begin
                            // Unmapped or malformed: answer at once, never touch a slave
                            m_ready_r <= 1'b1;
                            m_err_r   <= 1'b1;
                            m_rdata_r <= {DATA_W{1'b0}};
                        end
                    end else begin
                        m_busy_r <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (sel_ready_s || timeout_s) begin
                        cnt_r     <= {CNT_W{1'b0}};
                        s_sel_r   <= {NUM_SLV{1'b0}};
                        s_rd_en_r <= 1'b0;
                        s_wr_en_r <= 1'b0;
                        m_ready_r <= 1'b1;
                        m_err_r   <= !sel_ready_s;
                        m_rdata_r <= (sel_ready_s && !wr_r) ? rdata_sel_s : {DATA_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    m_ready_r <= 1'b0;
                    m_err_r   <= 1'b0;
                    m_busy_r  <= 1'b0;
                end
                default: begin
                    m_ready_r <= 1'b0;
                    m_err_r   <= 1'b0;
                    m_busy_r  <= 1'b0;
                    s_sel_r   <= {NUM_SLV{1'b0}};
                    s_rd_en_r <= 1'b0;
                    s_wr_en_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_ERR_LOG_EN
    logic [ADDR_W-1:0] err_addr_r;
    logic [7:0]        err_count_r;

    // Error log: the timed-out address is rebuilt from the window base and latched offset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_addr_r  <= {ADDR_W{1'b0}};
            err_count_r <= 8'd0;
        end else if ((state_r == IDLE && state_nx == RESP) ||
                     (state_r == ACCESS && state_nx == RESP && !sel_ready_s)) begin
            err_addr_r  <= (state_r == IDLE) ? m_addr
                         : SLV_BASE + ADDR_W'(idx_r) * SLV_SIZE + s_addr_r;
            err_count_r <= (err_count_r == 8'd255) ? 8'd255 : err_count_r + 8'd1;
        end else begin
            err_addr_r  <= err_addr_r;
            err_count_r <= err_count_r;
        end
    end

    assign err_addr  = err_addr_r;
    assign err_count = err_count_r;
`endif

    assign m_rdata = m_rdata_r;
    assign m_ready = m_ready_r;
    assign m_err   = m_err_r;
    assign m_busy  = m_busy_r;
    assign s_sel   = s_sel_r;
    assign s_addr  = s_addr_r;
    assign s_wdata = s_wdata_r;
    assign s_rd_en = s_rd_en_r;
    assign s_wr_en = s_wr_en_r;

endmodule

// File: tb/tb_sys_bus_fabric.sv
// Randomized self-checking bench for sys_bus_fabric against a transaction-level reference model.
module tb_sys_bus_fabric;

    localparam int          NUM_SLV  = 4;
    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam longint      BASE     = 64'h3000;
    localparam longint      SIZE     = 64'h1000;
    localparam int          TIMEOUT  = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic                      m_rd_en, m_wr_en;
    logic [DATA_W-1:0]         m_rdata;
    logic                      m_ready, m_err, m_busy;
    logic [NUM_SLV-1:0]        s_sel;
    logic [ADDR_W-1:0]         s_addr;
    logic [DATA_W-1:0]         s_wdata;
    logic                      s_rd_en, s_wr_en;
    logic [NUM_SLV*DATA_W-1:0] s_rdata;
    logic [NUM_SLV-1:0]        s_ready;
`ifdef BUS_ERR_LOG_EN
    logic [ADDR_W-1:0]         err_addr;
    logic [7:0]                err_count;
    logic [ADDR_W-1:0]         err_addr_m;
    int                        err_cnt_m;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_rdata;

    sys_bus_fabric dut (
        .clk(clk), .reset(reset),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rd_en(m_rd_en), .m_wr_en(m_wr_en),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err), .m_busy(m_busy),
`ifdef BUS_ERR_LOG_EN
        .err_addr(err_addr), .err_count(err_count),
`endif
        .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rd_en(s_rd_en), .s_wr_en(s_wr_en), .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".m_ready"}, 64'(m_ready), 64'd0);
        check_val({tag, ".m_err"},   64'(m_err),   64'd0);
        check_val({tag, ".m_busy"},  64'(m_busy),  64'd0);
        check_val({tag, ".m_rdata"}, 64'(m_rdata), 64'd0);
        check_val({tag, ".s_sel"},   64'(s_sel),   64'd0);
        check_val({tag, ".s_addr"},  64'(s_addr),  64'd0);
        check_val({tag, ".s_wdata"}, 64'(s_wdata), 64'd0);
        check_val({tag, ".s_rd_en"}, 64'(s_rd_en), 64'd0);
        check_val({tag, ".s_wr_en"}, 64'(s_wr_en), 64'd0);
    endtask

    // One master transaction; wt = ACCESS cycles before the addressed slave answers
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input bit rd,
                           input bit wr, input int wt, input logic [31:0] rdat, input bit busy_req);
        longint             a;
        bit                 hit, err_path, exp_err;
        int                 idx, exp_lat, got_lat, strobes;
        logic [31:0]        off, exp_data;
        logic [NUM_SLV-1:0] oh;
        a        = longint'(addr);
        hit      = (a >= BASE) && (a < BASE + NUM_SLV * SIZE);
        idx      = hit ? int'((a - BASE) / SIZE) : 0;
        off      = hit ? 32'((a - BASE) % SIZE) : 32'd0;
        oh       = NUM_SLV'(1) << idx;
        err_path = !hit || (rd && wr);
        if (err_path) begin
            exp_lat = 1; exp_err = 1'b1; exp_data = 32'd0;
        end else if (wt < TIMEOUT) begin
            exp_lat = 2 + wt; exp_err = 1'b0; exp_data = rd ? rdat : 32'd0;
        end else begin
            exp_lat = 1 + TIMEOUT; exp_err = 1'b1; exp_data = 32'd0;
        end
        got_lat = -1;
        strobes = 0;

        @(negedge clk);
        m_addr = addr; m_wdata = wdata; m_rd_en = rd; m_wr_en = wr;
        @(negedge clk);
        m_rd_en = 1'b0; m_wr_en = 1'b0;
        for (int c = 1; c <= TIMEOUT + 4; c++) begin
            if (m_ready === 1'b1) begin
                got_lat = c;
                check_val("resp.err",   64'(m_err),   64'(exp_err));
                check_val("resp.rdata", 64'(m_rdata), 64'(exp_data));
                check_val("resp.s_sel", 64'(s_sel),   64'd0);
                check_val("resp.strb",  64'(s_rd_en | s_wr_en), 64'd0);
                check_val("resp.busy",  64'(m_busy),  64'd1);
                if (busy_req) begin
                    m_addr = 32'h3000; m_rd_en = 1'b1;
                end
                break;
            end
            check_val("acc.busy", 64'(m_busy), 64'd1);
            if (!err_path) begin
                check_val("acc.s_sel",  64'(s_sel),   64'(oh));
                check_val("acc.s_addr", 64'(s_addr),  64'(off));
                check_val("acc.rd_en",  64'(s_rd_en), 64'(rd));
                check_val("acc.wr_en",  64'(s_wr_en), 64'(wr));
                if (wr) check_val("acc.s_wdata", 64'(s_wdata), 64'(wdata));
            end
            strobes += int'(s_rd_en | s_wr_en);
            for (int s = 0; s < NUM_SLV; s++) s_rdata[s*DATA_W +: DATA_W] = $urandom;
            s_rdata[idx*DATA_W +: DATA_W] = rdat;
            s_ready = NUM_SLV'($urandom) & ~oh;
            if (hit && (c - 1 == wt)) s_ready = s_ready | oh;
            if (busy_req) begin
                m_addr = 32'h3000; m_rd_en = 1'b1;
            end
            @(negedge clk);
            m_rd_en = 1'b0; s_ready = '0;
        end
        check_val("latency", 64'(got_lat), 64'(exp_lat));
        check_val("strobe_cycles", 64'(strobes), 64'(err_path ? 0 : exp_lat - 1));
        last_rdata = exp_data;
`ifdef BUS_ERR_LOG_EN
        if (exp_err) begin
            err_addr_m = addr;
            err_cnt_m  = (err_cnt_m < 255) ? err_cnt_m + 1 : 255;
        end
`endif
        @(negedge clk);
        m_rd_en = 1'b0;
        check_val("post.m_ready", 64'(m_ready), 64'd0);
        check_val("post.m_busy",  64'(m_busy),  64'd0);
        check_val("post.hold",    64'(m_rdata), 64'(last_rdata));
`ifdef BUS_ERR_LOG_EN
        check_val("log.count", 64'(err_count), 64'(err_cnt_m));
        if (err_cnt_m > 0) check_val("log.addr", 64'(err_addr), 64'(err_addr_m));
`endif
    endtask

    // Reset lands in the second ACCESS cycle of a never-answered read
    task automatic run_reset_mid();
        @(negedge clk);
        m_addr = 32'h3000; m_rd_en = 1'b1; m_wr_en = 1'b0;
        @(negedge clk);
        m_rd_en = 1'b0;
        check_val("rst.s_rd_en1", 64'(s_rd_en), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("rst_mid");
        last_rdata = 32'd0;
`ifdef BUS_ERR_LOG_EN
        err_cnt_m = 0; err_addr_m = '0;
        check_val("rst.log_count", 64'(err_count), 64'd0);
`endif
        @(negedge clk);
        check_val("rst.no_ready", 64'(m_ready), 64'd0);
    endtask

    initial begin
        int          r, slv, wt;
        bit          rd, wr;
        logic [31:0] addr;
        logic [31:0] edges [4];
        edges[0] = 32'h3000; edges[1] = 32'h6FFC; edges[2] = 32'h7000; edges[3] = 32'h2FFC;
        reset = 1'b1; m_addr = '0; m_wdata = '0; m_rd_en = 1'b0; m_wr_en = 1'b0;
        s_rdata = '0; s_ready = '0; last_rdata = 32'd0;
`ifdef BUS_ERR_LOG_EN
        err_cnt_m = 0; err_addr_m = '0;
`endif
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        run_txn(32'h4004, 32'h0,  1'b1, 1'b0, 2,    32'hDEADBEEF, 1'b0);
        run_txn(32'h3010, 32'h55, 1'b0, 1'b1, 0,    32'hA5A5A5A5, 1'b0);
        run_txn(32'h9000, 32'h0,  1'b1, 1'b0, 0,    32'h11111111, 1'b0);
        run_txn(32'h5000, 32'h0,  1'b1, 1'b0, 1000, 32'h22222222, 1'b0);
        run_txn(32'h3000, 32'h0,  1'b1, 1'b0, 0,    32'h12345678, 1'b0);
        run_txn(32'h3000, 32'h77, 1'b1, 1'b1, 0,    32'h33333333, 1'b1);
        run_txn(32'h6FFC, 32'h0,  1'b1, 1'b0, 1,    32'hCAFEF00D, 1'b1);
        run_txn(32'h5008, 32'h0,  1'b1, 1'b0, TIMEOUT - 1, 32'h0BADC0DE, 1'b0);
        run_txn(32'h7000, 32'h0,  1'b1, 1'b0, 0,    32'h44444444, 1'b0);
        run_txn(32'h2FFC, 32'h9,  1'b0, 1'b1, 0,    32'h55555555, 1'b0);
        run_reset_mid();
        run_txn(32'h3000, 32'h0,  1'b1, 1'b0, 0,    32'h87654321, 1'b0);

        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            slv = $urandom_range(0, NUM_SLV - 1);
            if (r < 6)       addr = 32'(BASE + slv * SIZE) + 32'($urandom_range(0, 32'h3FF)) * 32'd4;
            else if (r == 6) addr = 32'h7000 + 32'($urandom_range(0, 32'hFFFF));
            else if (r == 7) addr = 32'($urandom_range(0, 32'h2FFF));
            else if (r == 8) addr = edges[$urandom_range(0, 3)];
            else             addr = $urandom;
            r = $urandom_range(0, 9);
            if (r < 6)       wt = $urandom_range(0, 3);
            else if (r < 8)  wt = TIMEOUT - $urandom_range(1, 2);
            else             wt = TIMEOUT + $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            rd = (r == 0) || (r > 4);
            wr = (r < 5);
            run_txn(addr, $urandom, rd, wr, wt, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
